// File: rtl/pixel_plot_sink.sv
// pixel_plot_sink: queues (x, y, color) plot requests and writes them to the framebuffer port
// Optional feature macro: PIXEL_SINK_CLIP_EN (drop and count off-screen requests)
module pixel_plot_sink #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              plot_valid,
    output logic              plot_ready,
    input  logic [9:0]        x_in,
    input  logic [8:0]        y_in,
    input  logic [2:0]        color_in,
    output logic              fb_req,
    input  logic              fb_ack,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_color,
    output logic              busy,
    output logic [15:0]       clip_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int DW = ADDR_W + 3;

    logic [DW-1:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic              full, empty, accept, in_range, push, pop;
    logic [ADDR_W-1:0] push_addr;

    // Handshake, address arithmetic and queue control
    always_comb begin
        full       = count == (PW + 1)'(FIFO_DEPTH);
        empty      = count == '0;
        plot_ready = !reset && !full;
        accept     = plot_valid && plot_ready;
        push_addr  = ADDR_W'(32'(y_in) * 32'(SCREEN_W) + 32'(x_in));
`ifdef PIXEL_SINK_CLIP_EN
        in_range   = (32'(x_in) < 32'(SCREEN_W)) && (32'(y_in) < 32'(SCREEN_H));
`else
        in_range   = 1'b1;
`endif
        push       = accept && in_range;
        pop        = !empty && (!fb_req || fb_ack);
        busy       = !empty || fb_req;
    end

    // Queue pointers and occupancy; count is one bit wider than the pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + (PW + 1)'(push) - (PW + 1)'(pop);
        end
    end

    // Queue storage holds {addr, color}; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {push_addr, color_in};
    end

    // Output holding slot: reload from the head on retire so writes can go back-to-back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_req   <= 1'b0;
            fb_addr  <= '0;
            fb_color <= '0;
        end else if (pop) begin
            fb_req              <= 1'b1;
            {fb_addr, fb_color} <= mem[rd_ptr];
        end else if (fb_ack) begin
            fb_req <= 1'b0;
        end
    end

`ifdef PIXEL_SINK_CLIP_EN
    // Count accepted but off-screen requests, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) clip_count <= '0;
        else if (accept && !in_range && clip_count != 16'hFFFF) clip_count <= clip_count + 1'b1;
    end
`else
    assign clip_count = '0;
`endif
endmodule

// File: tb/tb_pixel_plot_sink.sv
// tb_pixel_plot_sink: directed self-checking bench for pixel_plot_sink
module tb_pixel_plot_sink;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        plot_valid = 1'b0;
    logic        plot_ready;
    logic [9:0]  x_in = '0;
    logic [8:0]  y_in = '0;
    logic [2:0]  color_in = '0;
    logic        fb_req;
    logic        fb_ack = 1'b0;
    logic [18:0] fb_addr;
    logic [2:0]  fb_color;
    logic        busy;
    logic [15:0] clip_count;
    int          n_checks = 0;
    int          n_fail = 0;

    pixel_plot_sink dut (
        .clk(clk), .reset(reset), .plot_valid(plot_valid), .plot_ready(plot_ready),
        .x_in(x_in), .y_in(y_in), .color_in(color_in), .fb_req(fb_req), .fb_ack(fb_ack),
        .fb_addr(fb_addr), .fb_color(fb_color), .busy(busy), .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        n_checks++; if (fb_req !== 1'b0) begin n_fail++; $display("FAIL rst_fb_req: got %0b expected 0", fb_req); end
        n_checks++; if (fb_addr !== 19'd0) begin n_fail++; $display("FAIL rst_fb_addr: got %0d expected 0", fb_addr); end
        n_checks++; if (fb_color !== 3'd0) begin n_fail++; $display("FAIL rst_fb_color: got %0d expected 0", fb_color); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        n_checks++; if (clip_count !== 16'd0) begin n_fail++; $display("FAIL rst_clip: got %0d expected 0", clip_count); end
        n_checks++; if (plot_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b expected 0", plot_ready); end
        reset = 1'b0;
        #1;
        n_checks++; if (plot_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %0b expected 1", plot_ready); end
        tick;
        fb_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            plot_valid = 1'b1; x_in = 10'(i + 1); y_in = 9'd1; color_in = 3'(i);
            tick;
        end
        plot_valid = 1'b0;
        n_checks++; if (fb_req !== 1'b1) begin n_fail++; $display("FAIL mid_fb_req: got %0b expected 1", fb_req); end
        reset = 1'b1;
        #1;
        n_checks++; if (fb_req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req: got %0b expected 0", fb_req); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %0b expected 0", busy); end
        n_checks++; if (plot_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %0b expected 0", plot_ready); end
        tick;
        n_checks++; if (fb_req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_hold: got %0b expected 0", fb_req); end
        reset = 1'b0;
        fb_ack = 1'b1;
        #1;
        n_checks++; if (plot_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rel_ready: got %0b expected 1", plot_ready); end
        for (int c = 0; c < 5; c++) begin
            tick;
            n_checks++; if (fb_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stale_write: cycle %0d got req=%0b busy=%0b expected 0/0", c, fb_req, busy); end
        end
    endtask

    task automatic test_single;
        fb_ack = 1'b1;
        plot_valid = 1'b1; x_in = 10'd5; y_in = 9'd2; color_in = 3'b100;
        tick;
        plot_valid = 1'b0;
        n_checks++; if (fb_req !== 1'b0) begin n_fail++; $display("FAIL single_latency: got req=%0b expected 0", fb_req); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %0b expected 1", busy); end
        tick;
        n_checks++; if (fb_req !== 1'b1) begin n_fail++; $display("FAIL single_req: got %0b expected 1", fb_req); end
        n_checks++; if (fb_addr !== 19'd1285) begin n_fail++; $display("FAIL single_addr: got %0d expected 1285", fb_addr); end
        n_checks++; if (fb_color !== 3'd4) begin n_fail++; $display("FAIL single_color: got %0d expected 4", fb_color); end
        tick;
        n_checks++; if (fb_req !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got %0b expected 0", fb_req); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %0b expected 0", busy); end
    endtask

    task automatic test_full;
        logic [18:0] exp_addr [6];
        int k;
        logic pushed;
        for (int i = 0; i < 6; i++) exp_addr[i] = 19'((10 + i) * 640 + i * 7);
        fb_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            plot_valid = 1'b1; x_in = 10'(i * 7); y_in = 9'(10 + i); color_in = 3'(i);
            n_checks++; if (plot_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_push%0d: got %0b expected 1", i, plot_ready); end
            tick;
        end
        n_checks++; if (plot_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b expected 0", plot_ready); end
        x_in = 10'd35; y_in = 9'd15; color_in = 3'd5;
        for (int c = 0; c < 3; c++) begin
            tick;
            n_checks++; if (plot_ready !== 1'b0) begin n_fail++; $display("FAIL full_holdoff%0d: got %0b expected 0", c, plot_ready); end
            n_checks++; if (fb_req !== 1'b1 || fb_addr !== exp_addr[0]) begin n_fail++; $display("FAIL full_hold_addr%0d: got req=%0b addr=%0d expected 1/%0d", c, fb_req, fb_addr, exp_addr[0]); end
        end
        fb_ack = 1'b1;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            pushed = plot_valid && plot_ready;
            if (fb_req && fb_ack) begin
                n_checks++;
                if (k >= 6 || fb_addr !== exp_addr[k] || fb_color !== 3'(k)) begin
                    n_fail++; $display("FAIL full_drain%0d: got addr=%0d color=%0d expected addr=%0d color=%0d", k, fb_addr, fb_color, (k < 6) ? exp_addr[k] : 19'd0, 3'(k));
                end
                k++;
            end
            tick;
            if (pushed) plot_valid = 1'b0;
        end
        n_checks++; if (k != 6) begin n_fail++; $display("FAIL full_write_count: got %0d expected 6", k); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_idle: got %0b expected 0", busy); end
    endtask

    task automatic test_back_to_back;
        int xs [6] = '{0, 639, 1, 0, 100, 639};
        int ys [6] = '{0, 479, 0, 1, 200, 0};
        logic [18:0] exp_addr [6] = '{19'd0, 19'd307199, 19'd1, 19'd640, 19'd128100, 19'd639};
        fb_ack = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 6) begin
                plot_valid = 1'b1; x_in = 10'(xs[c]); y_in = 9'(ys[c]); color_in = 3'(c + 1);
                n_checks++; if (plot_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %0b expected 1", c, plot_ready); end
            end else begin
                plot_valid = 1'b0;
            end
            if (c >= 2) begin
                n_checks++;
                if (fb_req !== 1'b1 || fb_addr !== exp_addr[c-2] || fb_color !== 3'(c - 1)) begin
                    n_fail++; $display("FAIL b2b_write%0d: got req=%0b addr=%0d color=%0d expected 1/%0d/%0d", c - 2, fb_req, fb_addr, fb_color, exp_addr[c-2], 3'(c - 1));
                end
            end
            tick;
        end
        n_checks++; if (fb_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got req=%0b busy=%0b expected 0/0", fb_req, busy); end
    endtask

    task automatic test_ack_toggle;
        logic acks [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [18:0] held;
        int w;
        fb_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            plot_valid = 1'b1; x_in = 10'(20 + i); y_in = 9'd3; color_in = 3'(i + 2);
            tick;
        end
        plot_valid = 1'b0;
        w = 0;
        held = '0;
        for (int c = 0; c < 4; c++) begin
            fb_ack = acks[c];
            if (c == 1) held = fb_addr;
            if (c == 2) begin
                n_checks++; if (fb_req !== 1'b1 || fb_addr !== held) begin n_fail++; $display("FAIL toggle_stable: got req=%0b addr=%0d expected 1/%0d", fb_req, fb_addr, held); end
            end
            if (fb_req && fb_ack) begin
                n_checks++;
                if (fb_addr !== 19'(1940 + w) || fb_color !== 3'(w + 2)) begin
                    n_fail++; $display("FAIL toggle_write%0d: got addr=%0d color=%0d expected %0d/%0d", w, fb_addr, fb_color, 1940 + w, w + 2);
                end
                w++;
            end
            tick;
        end
        n_checks++; if (w != 3) begin n_fail++; $display("FAIL toggle_count: got %0d expected 3", w); end
        fb_ack = 1'b1;
        n_checks++; if (fb_req !== 1'b1 || fb_addr !== 19'd1943) begin n_fail++; $display("FAIL toggle_last: got req=%0b addr=%0d expected 1/1943", fb_req, fb_addr); end
        tick;
        n_checks++; if (fb_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL toggle_idle: got req=%0b busy=%0b expected 0/0", fb_req, busy); end
    endtask

    task automatic test_clip;
        fb_ack = 1'b1;
`ifdef PIXEL_SINK_CLIP_EN
        plot_valid = 1'b1; x_in = 10'd640; y_in = 9'd0; color_in = 3'd7;
        n_checks++; if (plot_ready !== 1'b1) begin n_fail++; $display("FAIL clip_ready_x: got %0b expected 1", plot_ready); end
        tick;
        x_in = 10'd0; y_in = 9'd480;
        n_checks++; if (plot_ready !== 1'b1) begin n_fail++; $display("FAIL clip_ready_y: got %0b expected 1", plot_ready); end
        tick;
        plot_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (fb_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL clip_no_write%0d: got req=%0b busy=%0b expected 0/0", c, fb_req, busy); end
            tick;
        end
        n_checks++; if (clip_count !== 16'd2) begin n_fail++; $display("FAIL clip_count: got %0d expected 2", clip_count); end
`else
        plot_valid = 1'b1; x_in = 10'd640; y_in = 9'd0; color_in = 3'd7;
        tick;
        x_in = 10'd0; y_in = 9'd480; color_in = 3'd1;
        tick;
        plot_valid = 1'b0;
        n_checks++; if (fb_req !== 1'b1 || fb_addr !== 19'd640 || fb_color !== 3'd7) begin n_fail++; $display("FAIL noclip_x: got req=%0b addr=%0d color=%0d expected 1/640/7", fb_req, fb_addr, fb_color); end
        tick;
        n_checks++; if (fb_req !== 1'b1 || fb_addr !== 19'd307200 || fb_color !== 3'd1) begin n_fail++; $display("FAIL noclip_y: got req=%0b addr=%0d color=%0d expected 1/307200/1", fb_req, fb_addr, fb_color); end
        tick;
        n_checks++; if (fb_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL noclip_idle: got req=%0b busy=%0b expected 0/0", fb_req, busy); end
        n_checks++; if (clip_count !== 16'd0) begin n_fail++; $display("FAIL noclip_count: got %0d expected 0", clip_count); end
`endif
    endtask

    initial begin
        test_reset;
        test_single;
        test_full;
        test_back_to_back;
        test_ack_toggle;
        test_clip;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
